// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM encoding,
// default memory size and the wait-counter range.
package mem_ctrl_pkg;

    localparam int unsigned RAM_SIZE_BIT_DEFAULT = 8;
    localparam int unsigned WAIT_CYCLES_MAX      = 15;
    localparam int unsigned CNT_W                = $clog2(WAIT_CYCLES_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational legality check of a CPU byte address against a word-addressed
// memory of 2**RAM_SIZE_BIT words.
module mem_addr_check
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned RAM_SIZE_BIT = RAM_SIZE_BIT_DEFAULT
) (
    input  logic [31:0] addr,
    output logic        misaligned,
    output logic        out_of_range
);

    assign misaligned = |addr[1:0];

    generate
        if (RAM_SIZE_BIT + 2 < 32) begin : g_range
            // Word-index bits never influence legality.
            logic unused_word_idx;
            assign unused_word_idx = ^addr[RAM_SIZE_BIT+1:2];
            assign out_of_range    = |addr[31:RAM_SIZE_BIT+2];
        end else begin : g_full
            logic unused_upper;
            assign unused_upper = ^addr[31:2];
            assign out_of_range = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-memory access controller: one request at a time, fixed wait cycles.
// Address checking and rsp_err are enabled by defining MEM_ACCESS_CTRL_ERR_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned RAM_SIZE_BIT = RAM_SIZE_BIT_DEFAULT,
    parameter int unsigned WAIT_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               write_q;
    logic               err_q;
    logic               req_err;
    logic [31:0]        req_addr_eff;
    logic               misaligned;
    logic               out_of_range;
    logic               accept;
    logic               last_wait;

    mem_addr_check #(
        .RAM_SIZE_BIT (RAM_SIZE_BIT)
    ) u_addr_check (
        .addr         (req_addr),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

`ifdef MEM_ACCESS_CTRL_ERR_EN
    assign req_err      = misaligned | out_of_range;
    assign req_addr_eff = req_addr;
    assign rsp_err      = (state_q == RESP) & err_q;
`else
    // Without checking, low address bits are dropped and every request waits.
    logic unused_chk;
    assign unused_chk   = misaligned | out_of_range | err_q;
    assign req_err      = 1'b0;
    assign req_addr_eff = {req_addr[31:2], 2'b00};
    assign rsp_err      = 1'b0;
`endif

    assign accept    = (state_q == IDLE) & req_valid;
    assign last_wait = (state_q == WAIT) & (cnt_q == '0);
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr_eff;
                wdata_q <= req_wdata;
                write_q <= req_write;
                err_q   <= req_err;
                if (req_err) begin
                    rdata_q <= '0;
                end
            end
            if (last_wait) begin
                rdata_q <= write_q ? '0 : mem_rdata;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                mem_address    = addr_q;
                mem_write_data = wdata_q;
                mem_read       = ~write_q;
                // The store strobe is confined to the final wait cycle.
                if (cnt_q == '0) begin
                    mem_write = write_q;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_CYCLES=1 and WAIT_CYCLES=3 instances.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        rv1, wr1, rr1, rsv1, rse1, mr1, mw1;
    logic [31:0] addr1, wd1, rsd1, ma1, mwd1, mrd1;
    logic        rv3, wr3, rr3, rsv3, rse3, mr3, mw3;
    logic [31:0] addr3, wd3, rsd3, ma3, mwd3, mrd3;

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mem_access_ctrl #(.RAM_SIZE_BIT(8), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(rv1), .req_ready(rr1), .req_write(wr1),
        .req_addr(addr1), .req_wdata(wd1),
        .rsp_valid(rsv1), .rsp_rdata(rsd1), .rsp_err(rse1),
        .mem_address(ma1), .mem_write_data(mwd1),
        .mem_read(mr1), .mem_write(mw1), .mem_rdata(mrd1)
    );

    mem_access_ctrl #(.RAM_SIZE_BIT(8), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(rv3), .req_ready(rr3), .req_write(wr3),
        .req_addr(addr3), .req_wdata(wd3),
        .rsp_valid(rsv3), .rsp_rdata(rsd3), .rsp_err(rse3),
        .mem_address(ma3), .mem_write_data(mwd3),
        .mem_read(mr3), .mem_write(mw3), .mem_rdata(mrd3)
    );

    always @(posedge clk) begin
        if (mw1) mem1[ma1[9:2]] <= mwd1;
        if (mw3) mem3[ma3[9:2]] <= mwd3;
    end
    assign mrd1 = mem1[ma1[9:2]];
    assign mrd3 = mem3[ma3[9:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        rv1 = 0; wr1 = 0; addr1 = '0; wd1 = '0;
        rv3 = 0; wr3 = 0; addr3 = '0; wd3 = '0;
        #2;
        check("rst_ready1", rr1, 1);
        check("rst_ready3", rr3, 1);
        check("rst_rsp_valid", rsv1, 0);
        check("rst_mem_wr", mw1, 0);
        check("rst_mem_rd", mr1, 0);
        check("rst_mem_addr", ma1, 32'h0);
        check("rst_rdata", rsd1, 32'h0);
        check("rst_err", rse1, 0);
        tick();
        reset = 1'b1;

        // W=1 store 0x40 <- DEADBEEF
        rv1 = 1; wr1 = 1; addr1 = 32'h40; wd1 = 32'hDEADBEEF;
        check("st_ready_idle", rr1, 1);
        tick();
        rv1 = 0;
        check("st_mem_write", mw1, 1);
        check("st_mem_read", mr1, 0);
        check("st_mem_addr", ma1, 32'h40);
        check("st_mem_wdata", mwd1, 32'hDEADBEEF);
        check("st_ready_busy", rr1, 0);
        check("st_no_rsp_yet", rsv1, 0);
        tick();
        check("st_rsp_valid", rsv1, 1);
        check("st_rsp_err", rse1, 0);
        check("st_rsp_rdata", rsd1, 32'h0);
        check("st_mem_write_off", mw1, 0);
        check("st_mem_content", mem1[16], 32'hDEADBEEF);
        tick();
        check("st_rsp_done", rsv1, 0);
        check("st_back_idle", rr1, 1);

        // W=1 load 0x40
        rv1 = 1; wr1 = 0; addr1 = 32'h40;
        tick();
        rv1 = 0;
        check("ld_mem_read", mr1, 1);
        check("ld_mem_write", mw1, 0);
        check("ld_mem_addr", ma1, 32'h40);
        tick();
        check("ld_rsp_valid", rsv1, 1);
        check("ld_rsp_rdata", rsd1, 32'hDEADBEEF);
        check("ld_rsp_err", rse1, 0);
        check("ld_mem_read_off", mr1, 0);
        tick();
        check("ld_rdata_hold", rsd1, 32'hDEADBEEF);
        check("ld_rsp_done", rsv1, 0);

        // W=1 store word 0 so aliasing of 0x400 is observable
        rv1 = 1; wr1 = 1; addr1 = 32'h0; wd1 = 32'hCAFE0001;
        tick();
        rv1 = 0;
        tick();
        tick();
        check("st0_content", mem1[0], 32'hCAFE0001);

        // Misaligned load 0x42
        rv1 = 1; wr1 = 0; addr1 = 32'h42;
        tick();
        rv1 = 0;
`ifdef MEM_ACCESS_CTRL_ERR_EN
        check("mis_rsp_valid", rsv1, 1);
        check("mis_rsp_err", rse1, 1);
        check("mis_rsp_rdata", rsd1, 32'h0);
        check("mis_mem_read", mr1, 0);
        check("mis_mem_write", mw1, 0);
`else
        check("mis_mem_read", mr1, 1);
        check("mis_mem_addr", ma1, 32'h40);
        tick();
        check("mis_rsp_valid", rsv1, 1);
        check("mis_rsp_err", rse1, 0);
        check("mis_rsp_rdata", rsd1, 32'hDEADBEEF);
`endif
        tick();
        check("mis_idle", rr1, 1);

        // Out-of-range load 0x400
        rv1 = 1; wr1 = 0; addr1 = 32'h400;
        tick();
        rv1 = 0;
`ifdef MEM_ACCESS_CTRL_ERR_EN
        check("oor_rsp_valid", rsv1, 1);
        check("oor_rsp_err", rse1, 1);
        check("oor_rsp_rdata", rsd1, 32'h0);
        check("oor_mem_read", mr1, 0);
        check("oor_mem_write", mw1, 0);
`else
        check("oor_mem_read", mr1, 1);
        check("oor_mem_addr", ma1, 32'h400);
        tick();
        check("oor_rsp_valid", rsv1, 1);
        check("oor_rsp_err", rse1, 0);
        check("oor_rsp_rdata", rsd1, 32'hCAFE0001);
`endif
        tick();
        check("oor_idle", rr1, 1);

        // W=3 store 0x80 with req_valid held high, second request is a load
        rv3 = 1; wr3 = 1; addr3 = 32'h80; wd3 = 32'h11223344;
        check("w3_ready_idle", rr3, 1);
        tick();
        check("w3_c0_mem_write", mw3, 0);
        check("w3_c0_ready", rr3, 0);
        check("w3_c0_mem_addr", ma3, 32'h80);
        check("w3_c0_mem_read", mr3, 0);
        tick();
        check("w3_c1_mem_write", mw3, 0);
        check("w3_c1_ready", rr3, 0);
        tick();
        check("w3_c2_mem_write", mw3, 1);
        check("w3_c2_mem_wdata", mwd3, 32'h11223344);
        check("w3_c2_rsp_valid", rsv3, 0);
        tick();
        check("w3_c3_rsp_valid", rsv3, 1);
        check("w3_c3_mem_write", mw3, 0);
        check("w3_c3_ready", rr3, 0);
        check("w3_c3_content", mem3[32], 32'h11223344);
        wr3 = 0;
        tick();
        check("w3_c4_ready", rr3, 1);
        check("w3_c4_rsp_valid", rsv3, 0);
        tick();
        rv3 = 0;
        check("w3_c5_mem_read", mr3, 1);
        check("w3_c5_mem_addr", ma3, 32'h80);
        check("w3_c5_ready", rr3, 0);
        tick();
        tick();
        check("w3_c7_mem_read", mr3, 1);
        check("w3_c7_rsp_valid", rsv3, 0);
        tick();
        check("w3_c8_rsp_valid", rsv3, 1);
        check("w3_c8_rsp_rdata", rsd3, 32'h11223344);
        tick();

        // W=3 store aborted by reset during its commit cycle
        rv3 = 1; wr3 = 1; addr3 = 32'h80; wd3 = 32'h99999999;
        tick();
        rv3 = 0;
        tick();
        tick();
        check("abort_mem_write_pre", mw3, 1);
        reset = 1'b0;
        #1;
        check("abort_mem_write_async", mw3, 0);
        check("abort_ready", rr3, 1);
        check("abort_mem_addr", ma3, 32'h0);
        check("abort_rsp_valid", rsv3, 0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_rsp", rsv3, 0);
        end
        check("abort_ready_after", rr3, 1);
        check("abort_content", mem3[32], 32'h11223344);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
